// File: rtl/alu_result_writeback.sv
// Writeback stage: routes the ALU result into A/X/Y/SP or the memory data-out register,
// owns the N/Z flags, and stalls further writebacks while a memory write is outstanding.
module alu_result_writeback #(
  parameter int unsigned        DATA_W   = 8,
  parameter logic [DATA_W-1:0]  SP_RESET = 8'hFD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [2:0]        wb_code,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              update_nz,
  output logic              wb_ready,
  output logic [DATA_W-1:0] a_reg,
  output logic [DATA_W-1:0] x_reg,
  output logic [DATA_W-1:0] y_reg,
  output logic [DATA_W-1:0] sp,
  output logic [DATA_W-1:0] data_out,
  output logic              mem_wr_req,
  input  logic              mem_wr_ack,
  output logic              flag_n,
  output logic              flag_z,
  output logic              illegal_code
);

  typedef enum logic [0:0] {StIdle, StMemWait} state_e;

  localparam logic [2:0] CodeNone = 3'd0;
  localparam logic [2:0] CodeA    = 3'd1;
  localparam logic [2:0] CodeX    = 3'd2;
  localparam logic [2:0] CodeY    = 3'd3;
  localparam logic [2:0] CodeData = 3'd4;
  localparam logic [2:0] CodeSp   = 3'd5;

  state_e state;

  assign wb_ready = (state == StIdle);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= StIdle;
      a_reg        <= '0;
      x_reg        <= '0;
      y_reg        <= '0;
      sp           <= SP_RESET;
      data_out     <= '0;
      mem_wr_req   <= 1'b0;
      flag_n       <= 1'b0;
      flag_z       <= 1'b0;
      illegal_code <= 1'b0;
    end else begin
      illegal_code <= 1'b0;
      unique case (state)
        StIdle: begin
          // Ack is deliberately not looked at here, so a request lasts at least one cycle.
          if (wb_valid) begin
            case (wb_code)
              CodeNone: ;
              CodeA:    a_reg <= alu_result;
              CodeX:    x_reg <= alu_result;
              CodeY:    y_reg <= alu_result;
              CodeData: begin
                data_out   <= alu_result;
                mem_wr_req <= 1'b1;
                state      <= StMemWait;
              end
              CodeSp:   sp <= alu_result;
              default:  illegal_code <= 1'b1;
            endcase
            if (update_nz && (wb_code <= CodeData)) begin
              flag_n <= alu_result[DATA_W-1];
              flag_z <= (alu_result == '0);
            end
          end
        end
        StMemWait: begin
          if (mem_wr_ack) begin
            mem_wr_req <= 1'b0;
            state      <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_writeback.sv
// Directed bench for alu_result_writeback: expected architectural state is queued per
// cycle and compared against the DUT one time unit after each rising edge.
module tb_alu_result_writeback;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wb_valid;
  logic [2:0] wb_code;
  logic [7:0] alu_result;
  logic       update_nz;
  logic       wb_ready;
  logic [7:0] a_reg, x_reg, y_reg, sp, data_out;
  logic       mem_wr_req, mem_wr_ack;
  logic       flag_n, flag_z, illegal_code;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] a, x, y, sp, d;
    logic       req, rdy, n, z, ill;
  } exp_t;

  exp_t e;
  exp_t sb[$];

  alu_result_writeback dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_valid     (wb_valid),
    .wb_code      (wb_code),
    .alu_result   (alu_result),
    .update_nz    (update_nz),
    .wb_ready     (wb_ready),
    .a_reg        (a_reg),
    .x_reg        (x_reg),
    .y_reg        (y_reg),
    .sp           (sp),
    .data_out     (data_out),
    .mem_wr_req   (mem_wr_req),
    .mem_wr_ack   (mem_wr_ack),
    .flag_n       (flag_n),
    .flag_z       (flag_z),
    .illegal_code (illegal_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] code, input logic [7:0] res,
                       input logic unz, input logic ack);
    wb_valid   = v;
    wb_code    = code;
    alu_result = res;
    update_nz  = unz;
    mem_wr_ack = ack;
  endtask

  // Queue the expectation for the coming edge, then compare once the DUT has updated.
  task automatic cyc(input string tag);
    exp_t x;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({tag, ".a"},   a_reg,                x.a);
    chk({tag, ".x"},   x_reg,                x.x);
    chk({tag, ".y"},   y_reg,                x.y);
    chk({tag, ".sp"},  sp,                   x.sp);
    chk({tag, ".dout"}, data_out,            x.d);
    chk({tag, ".req"}, {7'd0, mem_wr_req},   {7'd0, x.req});
    chk({tag, ".rdy"}, {7'd0, wb_ready},     {7'd0, x.rdy});
    chk({tag, ".n"},   {7'd0, flag_n},       {7'd0, x.n});
    chk({tag, ".z"},   {7'd0, flag_z},       {7'd0, x.z});
    chk({tag, ".ill"}, {7'd0, illegal_code}, {7'd0, x.ill});
  endtask

  task automatic set_reset_exp();
    e = '{a: 8'h00, x: 8'h00, y: 8'h00, sp: 8'hFD, d: 8'h00,
          req: 1'b0, rdy: 1'b1, n: 1'b0, z: 1'b0, ill: 1'b0};
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 3'd1, 8'h99, 1'b1, 1'b0);
    set_reset_exp();
    cyc("rst0");
    cyc("rst1");
    rst_n = 1'b1;

    // Routing to A/X/Y/SP
    drive(1'b1, 3'd1, 8'h11, 1'b1, 1'b0); e.a = 8'h11;  cyc("wr_a");
    drive(1'b1, 3'd2, 8'h22, 1'b1, 1'b0); e.x = 8'h22;  cyc("wr_x");
    drive(1'b1, 3'd3, 8'h33, 1'b1, 1'b0); e.y = 8'h33;  cyc("wr_y");
    drive(1'b1, 3'd5, 8'h44, 1'b1, 1'b0); e.sp = 8'h44; cyc("wr_sp");

    // Flags
    drive(1'b1, 3'd0, 8'h00, 1'b1, 1'b0); e.z = 1'b1;                         cyc("cmp0");
    drive(1'b1, 3'd1, 8'h80, 1'b1, 1'b0); e.a = 8'h80; e.n = 1'b1; e.z = 1'b0; cyc("neg");
    drive(1'b1, 3'd1, 8'h05, 1'b0, 1'b0); e.a = 8'h05;                        cyc("nonz");
    drive(1'b1, 3'd5, 8'h00, 1'b1, 1'b0); e.sp = 8'h00;                       cyc("txs");
    drive(1'b0, 3'd1, 8'hEE, 1'b1, 1'b0);                                     cyc("novalid");

    // Reserved codes
    drive(1'b1, 3'd6, 8'hFF, 1'b1, 1'b0); e.ill = 1'b1; cyc("ill6");
    drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0); e.ill = 1'b0; cyc("ill6_end");
    drive(1'b1, 3'd7, 8'hFF, 1'b1, 1'b0); e.ill = 1'b1; cyc("ill7");
    drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0); e.ill = 1'b0; cyc("ill7_end");

    // Memory write; the coincident ack must be ignored in IDLE
    drive(1'b1, 3'd4, 8'hA5, 1'b0, 1'b1);
    e.d = 8'hA5; e.req = 1'b1; e.rdy = 1'b0;
    cyc("mem_acc");
    drive(1'b1, 3'd1, 8'h77, 1'b0, 1'b0);
    cyc("stall0");
    cyc("stall1");
    cyc("stall2");
    mem_wr_ack = 1'b1; e.req = 1'b0; e.rdy = 1'b1; cyc("ack");
    mem_wr_ack = 1'b0; e.a = 8'h77;                cyc("post_ack");

    // Reset during MEM_WAIT, then a late ack in IDLE
    drive(1'b1, 3'd4, 8'h3C, 1'b0, 1'b0);
    e.d = 8'h3C; e.req = 1'b1; e.rdy = 1'b0;
    cyc("mem2");
    drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0); cyc("mem2_wait");
    rst_n = 1'b0; set_reset_exp();         cyc("mid_rst");
    rst_n = 1'b1; mem_wr_ack = 1'b1;       cyc("late_ack");
    drive(1'b1, 3'd1, 8'h00, 1'b1, 1'b0); e.z = 1'b1; cyc("after_rst");
    drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
